ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Two-master arbiter that shares the single-port 32-bit byte-addressed data RAM (8-bit address, synchronous write, asynchronous chip-selected read) between master 0 (CPU load/store unit) and master 1 (program/data loader or debug port).
- Serializes transactions with round-robin fairness, drives the RAM control pins for exactly one cycle per access, registers read data and returns a one-cycle acknowledge.
- Rejects word-misaligned accesses without touching the RAM.

Parameters:
- ADDR_W, 8, RAM byte-address width.
- DATA_W, 32, data word width.
- CHECK_ALIGN, 1, when 1 a request with addr[1:0] != 0 is answered with err and no RAM access; when 0 alignment is not checked.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- m0_req  input  1  master 0 request; held high with addr/wdata/we stable until m0_ack.
- m0_we  input  1  master 0 write (1) / read (0).
- m0_addr  input  ADDR_W  master 0 byte address.
- m0_wdata  input  DATA_W  master 0 write data.
- m0_ack  output  1  one-cycle completion pulse.
- m0_err  output  1  valid with m0_ack; 1 = misaligned, not performed.
- m0_rdata  output  DATA_W  read data, valid during m0_ack for reads.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as master 0, for master 1.
- ram_cs  output  1  RAM chip select (read enable).
- ram_write  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_wdata  output  DATA_W  RAM write data.
- ram_rdata  input  DATA_W  RAM read data; high-Z when ram_cs is low.

Behaviour:
- FSM states: IDLE, ACCESS, DONE. Registers: state, gnt (1 bit: winning master), last (1 bit: last served master), rdata_q, ack/err pulses.
- Reset (async, rst_n low): state=IDLE, last=1 (so master 0 wins the first tie), gnt=0. All outputs are 0: m*_ack, m*_err, m*_rdata, ram_cs, ram_write, ram_addr, ram_wdata. Reset mid-ACCESS drops ram_write/ram_cs immediately; no partial transaction is acknowledged.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one request: gnt = that master, go to ACCESS.
- IDLE, both requests: gnt = !last (round-robin), go to ACCESS.
- ACCESS lasts one cycle:
  - ram_addr/ram_wdata are muxed combinationally from the granted master's inputs.
  - Granted write: ram_write=1, ram_cs=0; the RAM commits at the closing edge.
  - Granted read: ram_cs=1, ram_write=0; rdata_q <= ram_rdata at the closing edge.
  - Misaligned request with CHECK_ALIGN=1: ram_cs=0, ram_write=0, and err is latched.
  - At the closing edge: last <= gnt, state <= DONE.
- DONE lasts one cycle:
  - The granted m*_ack is 1, with m*_err as latched.
  - m*_rdata = rdata_q for reads; it holds its last value otherwise. Each master has its own rdata register and updates it only on its own read.
  - The other master's ack is 0.
  - All requests are ignored in DONE. Next state is IDLE.
- Outside ACCESS: ram_cs=0, ram_write=0, ram_addr=0, ram_wdata=0. The arbiter never drives both ram_cs and ram_write at once.
- Latency: request first sampled high at edge E → RAM access in the cycle after E → ack in the following cycle → earliest next grant sampled one cycle after ack. Minimum spacing is 3 cycles per transaction.
- A master may keep req high after ack to issue a new transaction. New addr/we/wdata must be valid from the cycle after ack.
- Dropping req before ack is a protocol violation. The arbiter still completes the granted access and pulses ack.
- Address arithmetic: no wrap handling in the arbiter; ram_addr is passed unmodified. The RAM handles byte lanes addr..addr+3.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to addr 0x10 → ram_write high for exactly 1 cycle with ram_addr=0x10; m0_ack 2 cycles after req sampled, m0_err=0; m0 then reads 0x10 → ram_cs 1 cycle, m0_rdata=0xDEADBEEF during m0_ack.
- m0 and m1 assert reads (0x04, 0x08) on the same cycle after reset → m0 served first, then m1; m1_ack exactly 3 cycles after m0_ack; rdata registers independent.
- Both masters hold req continuously for 6 transactions → grants alternate m0,m1,m0,m1,m0,m1; no master starves; ram_cs/ram_write are never high together.
- m1 writes addr 0x06 with CHECK_ALIGN=1 → no ram_write/ram_cs pulse, m1_ack=1 with m1_err=1; RAM contents at 0x04/0x08 unchanged on readback.
- rst_n pulled low during ACCESS of an m0 write → ram_write falls asynchronously, no m0_ack; after release, state=IDLE and the first tie goes to m0.
- Single master m1 issues back-to-back reads with req held high → one access every 3 cycles; m0_ack stays 0 throughout.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between two masters; misaligned requests get err without touching the RAM.
// Latency: grant at the sampling edge, RAM access the next cycle, ack the cycle after; masters stall by holding req until ack.
module ram_port_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int CHECK_ALIGN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_cs,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    logic              gnt;
    logic              last;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              misalign;
    logic              in_access;

    always_comb begin
        sel_we    = gnt ? m1_we    : m0_we;
        sel_addr  = gnt ? m1_addr  : m0_addr;
        sel_wdata = gnt ? m1_wdata : m0_wdata;
        misalign  = (CHECK_ALIGN != 0) && (sel_addr[1:0] != 2'b00);
        in_access = (state == ACCESS);
    end

    // RAM pins decode straight from state so an async reset drops them at once.
    always_comb begin
        ram_addr  = in_access ? sel_addr  : '0;
        ram_wdata = in_access ? sel_wdata : '0;
        ram_write = in_access &&  sel_we && !misalign;
        ram_cs    = in_access && !sel_we && !misalign;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last     <= 1'b1;
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        gnt   <= ~last;
                        state <= ACCESS;
                    end else if (m0_req) begin
                        gnt   <= 1'b0;
                        state <= ACCESS;
                    end else if (m1_req) begin
                        gnt   <= 1'b1;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    last  <= gnt;
                    state <= DONE;
                    if (gnt) begin
                        m1_ack <= 1'b1;
                        m1_err <= misalign;
                        if (!sel_we && !misalign) m1_rdata <= ram_rdata;
                    end else begin
                        m0_ack <= 1'b1;
                        m0_err <= misalign;
                        if (!sel_we && !misalign) m0_rdata <= ram_rdata;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
